// File: rtl/sqrt_arbiter.sv
// Round-robin front end that shares one pipelined square-root unit among
// NUM_REQ requesters and routes each in-order result back to its requester.
module sqrt_arbiter #(
  parameter int BIT_WIDTH       = 16,
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_data_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  output logic                           sqrt_valid_out,
  output logic [BIT_WIDTH-1:0]           sqrt_data_out,
  input  logic                           sqrt_valid_in,
  input  logic [BIT_WIDTH-1:0]           sqrt_result_in,
  output logic [NUM_REQ-1:0]             res_valid_out,
  output logic [BIT_WIDTH-1:0]           res_data_out,
  output logic                           busy_out,
  output logic                           err_out
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]     r_last_grant;
  logic                 r_sqrt_valid;
  logic [BIT_WIDTH-1:0] r_sqrt_data;
  logic [NUM_REQ-1:0]   r_res_valid;
  logic [BIT_WIDTH-1:0] r_res_data;
  logic                 r_err;

  logic [IDX_W-1:0]     r_tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  logic [NUM_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]     w_grant_idx;
  logic [IDX_W-1:0]     w_cand;
  logic                 w_found;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [BIT_WIDTH-1:0] w_sel_data;
  logic [NUM_REQ-1:0]   w_head_onehot;

  assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);

  // NOTE: combinational blocks use blocking '=' with every output defaulted
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_cand      = '0;
    w_found     = 1'b0;
    // First valid requester after the previous winner, wrapping around.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_found && req_valid_in[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
    end
    if (w_found && !w_full && !rst_in) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == IDX_W'(i)) begin
        w_sel_data = req_data_in[i*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  always_comb begin
    w_head_onehot = '0;
    w_head_onehot[r_tag_mem[r_rd_ptr]] = 1'b1;
  end

  assign w_push = |w_grant;
  assign w_pop  = sqrt_valid_in && !w_empty;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_sqrt_valid <= 1'b0;
      r_sqrt_data  <= '0;
    end else begin
      r_sqrt_valid <= w_push;
      if (w_push) begin
        r_sqrt_data  <= w_sel_data;
        r_last_grant <= w_grant_idx;
      end
    end
  end

  // NOTE: tag storage has no reset; entries are only meaningful below
  // r_count, which is reset, so clearing the array would buy nothing.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_grant_idx;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A result with no tag waiting is dropped and latched as an error.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_res_valid <= '0;
      r_res_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_res_valid <= '0;
      if (w_pop) begin
        r_res_valid <= w_head_onehot;
        r_res_data  <= sqrt_result_in;
      end
      if (sqrt_valid_in && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign req_ready_out  = w_grant;
  assign sqrt_valid_out = r_sqrt_valid;
  assign sqrt_data_out  = r_sqrt_data;
  assign res_valid_out  = r_res_valid;
  assign res_data_out   = r_res_data;
  assign busy_out       = !w_empty || r_sqrt_valid;
  assign err_out        = r_err;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a behavioural 9-stage square-root
// pipeline attached; the pipeline is never reset.
module tb_sqrt_arbiter;

  localparam int BW    = 16;
  localparam int NR    = 4;
  localparam int STAGE = BW / 2 + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*BW-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          sqrt_valid_out;
  logic [BW-1:0] sqrt_data_out;
  logic          sqrt_valid_in;
  logic [BW-1:0] sqrt_result_in;
  logic [NR-1:0] res_valid;
  logic [BW-1:0] res_data;
  logic          busy;
  logic          err;

  logic             force_mode  = 1'b0;
  logic             force_valid = 1'b0;
  logic [STAGE-1:0] pv = '0;
  logic [BW-1:0]    pd [STAGE];

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  sqrt_arbiter #(.BIT_WIDTH(BW), .NUM_REQ(NR), .MAX_OUTSTANDING(16)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .req_valid_in   (req_valid),
    .req_data_in    (req_data),
    .req_ready_out  (req_ready),
    .sqrt_valid_out (sqrt_valid_out),
    .sqrt_data_out  (sqrt_data_out),
    .sqrt_valid_in  (sqrt_valid_in),
    .sqrt_result_in (sqrt_result_in),
    .res_valid_out  (res_valid),
    .res_data_out   (res_data),
    .busy_out       (busy),
    .err_out        (err)
  );

  function automatic logic [BW-1:0] isqrt(input logic [BW-1:0] x);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    return BW'(r);
  endfunction

  always @(posedge clk) begin
    pv    <= {pv[STAGE-2:0], sqrt_valid_out};
    pd[0] <= isqrt(sqrt_data_out);
    for (int i = 1; i < STAGE; i++) pd[i] <= pd[i-1];
  end

  assign sqrt_valid_in  = force_mode ? force_valid : pv[STAGE-1];
  assign sqrt_result_in = pd[STAGE-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic set_data(input int idx, input logic [BW-1:0] val);
    req_data[idx*BW +: BW] = val;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next();
    next();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cnt;
    int c1;
    int c3;
    logic any;
    logic [NR-1:0] exp_grant [5];
    logic [BW-1:0] exp_res   [5];
    exp_grant[0] = 4'b0001; exp_grant[1] = 4'b0010; exp_grant[2] = 4'b0100;
    exp_grant[3] = 4'b1000; exp_grant[4] = 4'b0001;
    exp_res[0] = 16'd0; exp_res[1] = 16'd1; exp_res[2] = 16'd255;
    exp_res[3] = 16'd10; exp_res[4] = 16'd0;

    // Reset state, with every requester asking for service.
    rst = 1'b1;
    req_valid = '1;
    req_data  = '0;
    next();
    next();
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_sqrt_valid", sqrt_valid_out, 0);
    check("rst_sqrt_data", sqrt_data_out, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    req_valid = '0;
    next();
    rst = 1'b0;

    // Single request from requester 2: sqrt(144) = 12, 11 cycles later.
    req_valid = 4'b0100;
    set_data(2, 16'd144);
    #1;
    check("single_ready", req_ready, 4'b0100);
    next();
    req_valid = '0;
    #1;
    check("single_issue_valid", sqrt_valid_out, 1);
    check("single_issue_data", sqrt_data_out, 144);
    check("single_busy", busy, 1);
    next();
    #1;
    check("issue_idle_valid", sqrt_valid_out, 0);
    check("issue_hold_data", sqrt_data_out, 144);
    lat = 2;
    while (res_valid == '0 && lat < 40) begin
      next();
      #1;
      lat++;
    end
    check("single_latency", lat, 11);
    check("single_res_valid", res_valid, 4'b0100);
    check("single_res_data", res_data, 12);
    next();
    #1;
    check("res_strobe_one_cycle", res_valid, 0);
    check("res_hold_data", res_data, 12);
    check("single_idle_busy", busy, 0);

    // All four requesters: grants 0,1,2,3,0 back to back, results in order.
    do_reset();
    req_valid = 4'b1111;
    set_data(0, 16'd0);
    set_data(1, 16'd1);
    set_data(2, 16'd65535);
    set_data(3, 16'd100);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr_grant%0d", k), req_ready, exp_grant[k]);
      next();
    end
    req_valid = '0;
    #1;
    lat = 0;
    while (res_valid == '0 && lat < 40) begin
      next();
      #1;
      lat++;
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_res_valid%0d", k), res_valid, exp_grant[k]);
      check($sformatf("rr_res_data%0d", k), res_data, exp_res[k]);
      next();
      #1;
    end
    check("rr_idle_busy", busy, 0);

    // Fairness: requesters 1 and 3 alternate for 20 cycles.
    req_valid = 4'b1010;
    c1 = 0;
    c3 = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      check($sformatf("fair_grant%0d", k), req_ready, (k % 2 == 0) ? 4'b0010 : 4'b1000);
      if (req_ready == 4'b0010) c1++;
      if (req_ready == 4'b1000) c3++;
      next();
    end
    req_valid = '0;
    check("fair_count1", c1, 10);
    check("fair_count3", c3, 10);
    for (int k = 0; k < 15; k++) next();
    #1;
    check("fair_drained_busy", busy, 0);
    check("fair_err", err, 0);

    // Backpressure: results stalled, 16 transfers fill the tag FIFO.
    force_mode  = 1'b1;
    force_valid = 1'b0;
    req_valid   = 4'b1111;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req_ready != '0) cnt++;
      next();
    end
    #1;
    check("bp_transfers", cnt, 16);
    check("bp_full_ready", req_ready, 0);
    check("bp_full_busy", busy, 1);
    force_valid = 1'b1;
    next();
    force_valid = 1'b0;
    #1;
    check("bp_pop_res_valid", res_valid, 4'b0001);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (req_ready != '0) cnt++;
      next();
      #1;
    end
    check("bp_one_more", cnt, 1);
    check("bp_refull_ready", req_ready, 0);
    req_valid = '0;
    do_reset();
    for (int k = 0; k < 12; k++) next();
    force_mode = 1'b0;

    // Reset mid-flight: five issues, reset three cycles later.
    req_valid = 4'b0001;
    set_data(0, 16'd49);
    for (int k = 0; k < 5; k++) next();
    req_valid = '0;
    for (int k = 0; k < 3; k++) next();
    #1;
    check("mid_busy_before", busy, 1);
    rst = 1'b1;
    req_valid = 4'b0001;
    #1;
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_sqrt_valid", sqrt_valid_out, 0);
    check("mid_rst_sqrt_data", sqrt_data_out, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err, 0);
    next();
    rst = 1'b0;
    req_valid = '0;
    any = 1'b0;
    for (int k = 0; k < 15; k++) begin
      next();
      #1;
      if (res_valid != '0) any = 1'b1;
    end
    check("mid_no_res", any, 0);
    check("mid_err", err, 1);

    // Spurious result after reset.
    do_reset();
    #1;
    check("spur_err_clear", err, 0);
    force_mode  = 1'b1;
    force_valid = 1'b1;
    next();
    force_valid = 1'b0;
    #1;
    check("spur_err", err, 1);
    check("spur_res_valid", res_valid, 0);
    for (int k = 0; k < 3; k++) next();
    #1;
    check("spur_err_sticky", err, 1);
    force_mode = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
